ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver: de-glitches the PS/2 clock, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), checks framing and parity, aborts stalled frames on a watchdog, and queues good bytes in a small first-word-fall-through FIFO. It sits between the PS/2 pads and the keyboard/scan-code decoder, which pops bytes at its own pace.

## Interface
- FILTER_LEN, 8, PS/2 clock filter length in cycles (≥2)
- TIMEOUT_CYC, 5000, max cycles between falling edges inside a frame before abort
- FIFO_DEPTH, 4, byte FIFO entries (power of 2, ≥2)

- clk_ps2_rx  in  1  system clock
- reset_ps2_rx  in  1  reset; one clock, synchronous, active-high
- ps2d_ps2_rx  in  1  PS/2 data (pre-synchronised)
- ps2c_ps2_rx  in  1  PS/2 clock (pre-synchronised)
- rx_en_ps2_rx  in  1  allow start of a new frame
- rd_ps2_rx  in  1  pop FIFO head; ignored when empty
- dout_ps2_rx  out  8  FIFO head byte; valid when empty_ps2_rx=0
- empty_ps2_rx  out  1  FIFO empty
- rx_done_tick_ps2_rx  out  1  1-cycle pulse: good byte written
- parity_err_ps2_rx  out  1  1-cycle pulse: parity failure, byte dropped
- frame_err_ps2_rx  out  1  1-cycle pulse: bad start/stop or timeout
- overrun_ps2_rx  out  1  sticky: good byte dropped, FIFO full; cleared by rd_ps2_rx or reset
- busy_ps2_rx  out  1  frame in progress (state ≠ IDLE)

## Operation
- Filter: FILTER_LEN-bit shift register of ps2c_ps2_rx; filtered clock → 1 when all ones, → 0 when all zeros, else holds. fall_edge = filtered 1 now and 0 next.
- Shift register b (11 bits) shifts ps2d_ps2_rx in at MSB on every fall_edge accepted by FSM. After 11 shifts: b[0]=start, b[8:1]=data, b[9]=parity, b[10]=stop.
- FSM states IDLE, DATA, CHECK:
  - IDLE: fall_edge & rx_en_ps2_rx → shift, n←9, timer←0, → DATA. fall_edge with rx_en low ignored.
  - DATA: fall_edge → shift, timer←0; if n==0 → CHECK else n←n−1. No edge → timer+1; timer==TIMEOUT_CYC−1 → frame_err pulse, → IDLE.
  - CHECK (one cycle, → IDLE): priority 1 b[0]≠0 or b[10]≠1 → frame_err; 2 ^b[9:1]≠1 → parity_err; 3 FIFO full (after same-cycle read) → overrun set, byte dropped; else write b[8:1], rx_done_tick.
- rx_en_ps2_rx dropping mid-frame does not abort the frame.
- FIFO: first-word fall-through; read and write in the same cycle allowed, including when full (read frees slot first). Count width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- overrun set and rd same cycle: set wins.

## Timing
- Reset: all outputs 0 except empty_ps2_rx=1; FSM IDLE, filter reg 0, filtered clock 0, FIFO empty, timer/n/b 0. Reset mid-frame discards the partial frame.
- fall_edge occurs FILTER_LEN cycles after ps2c_ps2_rx settles low (clock glitches shorter than FILTER_LEN cycles produce no edge).
- Stop-bit fall_edge in cycle T → CHECK in T+1 (pulses asserted in T+1) → FIFO updated, empty_ps2_rx low from T+2; busy low from T+2.
- rd_ps2_rx in cycle T → new head/empty visible T+1.
- Error/done pulses are mutually exclusive, exactly one cycle.

## Test plan
- Frame 0x1C (parity 0, stop 1), FILTER_LEN=8 half-period 40 cycles → one rx_done_tick, dout=0x1C, empty low; rd → empty high next cycle.
- Frame 0xA5 with parity 0 → parity_err pulse, no rx_done_tick, FIFO stays empty.
- Frame 0x55 with stop bit 0, then start bit 1 case → frame_err pulse each, FIFO empty.
- Start + 3 bits then ps2c held high → frame_err exactly TIMEOUT_CYC cycles after last edge, busy low; following valid 0x3A received correctly.
- FIFO_DEPTH+1 frames 0x01..0x05, no rd → overrun high after 5th, pops yield 0x01..0x04; first rd clears overrun; full-FIFO read in the CHECK cycle of a frame → byte accepted, no overrun.
- ps2c glitches of 3 cycles low → no shift; reset_ps2_rx asserted mid-frame → busy 0, empty 1 next cycle, next frame correct.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: de-glitched clock, 11-bit frame check, first-word-fall-through byte FIFO.
// Pulses come one cycle after the stop-bit edge and the byte is at the head a cycle later; a full FIFO drops the byte and sets overrun.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_ps2_rx,
  input  logic       reset_ps2_rx,
  input  logic       ps2d_ps2_rx,
  input  logic       ps2c_ps2_rx,
  input  logic       rx_en_ps2_rx,
  input  logic       rd_ps2_rx,
  output logic [7:0] dout_ps2_rx,
  output logic       empty_ps2_rx,
  output logic       rx_done_tick_ps2_rx,
  output logic       parity_err_ps2_rx,
  output logic       frame_err_ps2_rx,
  output logic       overrun_ps2_rx,
  output logic       busy_ps2_rx
);
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TLAST = TIMEOUT_CYC - 1;
  localparam logic [TW-1:0] TIMER_MAX = TLAST[TW-1:0];
  localparam logic [AW:0]   FULL_CNT  = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  state_t                state, state_nxt;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  filt_clk, filt_clk_nxt, fall_edge;
  logic [10:0]           b, b_nxt;
  logic [3:0]            n, n_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic                  frame_ok;
  logic [7:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [AW:0]           count;
  logic                  rd_do, wr_do, full_eff;

  // Filtered clock only moves once the whole window agrees; otherwise it holds.
  always_comb begin
    filt_clk_nxt = filt_clk;
    if (&filt_reg)
      filt_clk_nxt = 1'b1;
    else if (~|filt_reg)
      filt_clk_nxt = 1'b0;
  end

  assign fall_edge = filt_clk & ~filt_clk_nxt;

  always_ff @(posedge clk_ps2_rx) begin
    if (reset_ps2_rx) begin
      filt_reg <= '0;
      filt_clk <= 1'b0;
      state    <= IDLE;
      b        <= '0;
      n        <= '0;
      timer    <= '0;
    end else begin
      filt_reg <= {ps2c_ps2_rx, filt_reg[FILTER_LEN-1:1]};
      filt_clk <= filt_clk_nxt;
      state    <= state_nxt;
      b        <= b_nxt;
      n        <= n_nxt;
      timer    <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    b_nxt             = b;
    n_nxt             = n;
    timer_nxt         = timer;
    frame_err_ps2_rx  = 1'b0;
    parity_err_ps2_rx = 1'b0;
    frame_ok          = 1'b0;
    case (state)
      IDLE: begin
        if (fall_edge && rx_en_ps2_rx) begin
          b_nxt     = {ps2d_ps2_rx, b[10:1]};
          n_nxt     = 4'd9;
          timer_nxt = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (fall_edge) begin
          b_nxt     = {ps2d_ps2_rx, b[10:1]};
          timer_nxt = '0;
          if (n == 4'd0)
            state_nxt = CHECK;
          else
            n_nxt = n - 4'd1;
        end else if (timer == TIMER_MAX) begin
          frame_err_ps2_rx = 1'b1;
          state_nxt        = IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        if (b[0] || !b[10])
          frame_err_ps2_rx = 1'b1;
        else if (^b[9:1] != 1'b1)
          parity_err_ps2_rx = 1'b1;
        else
          frame_ok = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pop in the CHECK cycle frees the slot the new byte lands in.
  assign rd_do               = rd_ps2_rx && (count != '0);
  assign full_eff            = (count == FULL_CNT) && !rd_do;
  assign wr_do               = frame_ok && !full_eff;
  assign rx_done_tick_ps2_rx = wr_do;
  assign empty_ps2_rx        = (count == '0);
  assign dout_ps2_rx         = empty_ps2_rx ? 8'h00 : mem[rd_ptr];
  assign busy_ps2_rx         = (state != IDLE);

  always_ff @(posedge clk_ps2_rx) begin
    if (wr_do)
      mem[wr_ptr] <= b[8:1];
  end

  always_ff @(posedge clk_ps2_rx) begin
    if (reset_ps2_rx) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      overrun_ps2_rx <= 1'b0;
    end else begin
      if (wr_do)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_do)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_do, rd_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (frame_ok && full_eff)
        overrun_ps2_rx <= 1'b1;
      else if (rd_ps2_rx)
        overrun_ps2_rx <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed frame table, hand-written corner sequences, randomized frames vs a queue model.
module tb_ps2_rx_fifo;
  localparam int FL    = 8;
  localparam int TO    = 5000;
  localparam int DEPTH = 4;

  logic       clk_ps2_rx = 1'b0;
  logic       reset_ps2_rx, ps2d_ps2_rx, ps2c_ps2_rx, rx_en_ps2_rx, rd_ps2_rx;
  logic [7:0] dout_ps2_rx;
  logic       empty_ps2_rx, rx_done_tick_ps2_rx, parity_err_ps2_rx, frame_err_ps2_rx;
  logic       overrun_ps2_rx, busy_ps2_rx;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk_ps2_rx          (clk_ps2_rx),
    .reset_ps2_rx        (reset_ps2_rx),
    .ps2d_ps2_rx         (ps2d_ps2_rx),
    .ps2c_ps2_rx         (ps2c_ps2_rx),
    .rx_en_ps2_rx        (rx_en_ps2_rx),
    .rd_ps2_rx           (rd_ps2_rx),
    .dout_ps2_rx         (dout_ps2_rx),
    .empty_ps2_rx        (empty_ps2_rx),
    .rx_done_tick_ps2_rx (rx_done_tick_ps2_rx),
    .parity_err_ps2_rx   (parity_err_ps2_rx),
    .frame_err_ps2_rx    (frame_err_ps2_rx),
    .overrun_ps2_rx      (overrun_ps2_rx),
    .busy_ps2_rx         (busy_ps2_rx)
  );

  always #5 clk_ps2_rx = ~clk_ps2_rx;

  int n_checks = 0, n_fail = 0;
  int n_done = 0, n_perr = 0, n_ferr = 0, n_excl = 0;
  int s_done, s_perr, s_ferr, s_excl;
  logic [7:0] q[$];
  logic       ovr_m = 1'b0;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk_ps2_rx) begin
    if (!reset_ps2_rx) begin
      if (rx_done_tick_ps2_rx) n_done++;
      if (parity_err_ps2_rx)   n_perr++;
      if (frame_err_ps2_rx)    n_ferr++;
      if ((rx_done_tick_ps2_rx && parity_err_ps2_rx) || (rx_done_tick_ps2_rx && frame_err_ps2_rx) ||
          (parity_err_ps2_rx && frame_err_ps2_rx))
        n_excl++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] d;
    logic       par, st, sp;
    int         en_mode;
    int         e_done, e_perr, e_ferr;
  } vec_t;

  vec_t vt[11];

  task automatic tick();
    @(posedge clk_ps2_rx);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_done = n_done; s_perr = n_perr; s_ferr = n_ferr; s_excl = n_excl;
  endtask

  task automatic expect_pulses(input int ed, input int ep, input int ef);
    check("done_cnt", n_done - s_done, ed);
    check("perr_cnt", n_perr - s_perr, ep);
    check("ferr_cnt", n_ferr - s_ferr, ef);
    check("pulse_excl", n_excl - s_excl, 0);
  endtask

  task automatic drive_bit(input logic v, input int half, input bit glitch, input bit rd_chk);
    ps2d_ps2_rx = v;
    if (glitch) begin
      repeat (half / 2) tick();
      ps2c_ps2_rx = 1'b0;
      repeat (3) tick();
      ps2c_ps2_rx = 1'b1;
      repeat (half - half / 2 - 3) tick();
    end else begin
      repeat (half) tick();
    end
    ps2c_ps2_rx = 1'b0;
    if (rd_chk) begin
      repeat (FL + 1) tick();
      rd_ps2_rx = 1'b1;
      #1;
      check("done_in_check", rx_done_tick_ps2_rx, 1);
      tick();
      rd_ps2_rx = 1'b0;
      check("ovr_after_check", overrun_ps2_rx, 0);
      check("busy_after_check", busy_ps2_rx, 0);
      repeat (half - FL - 2) tick();
    end else begin
      repeat (half) tick();
    end
    ps2c_ps2_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic st, input logic sp,
                            input int half, input bit glitch, input int en_mode, input bit rd_chk);
    logic [10:0] bits;
    bits = {sp, par, d, st};
    rx_en_ps2_rx = (en_mode != 1);
    for (int i = 0; i < 11; i++) begin
      drive_bit(bits[i], half, glitch, rd_chk && (i == 10));
      if (en_mode == 2 && i == 0) rx_en_ps2_rx = 1'b0;
    end
    repeat (30) tick();
    rx_en_ps2_rx = 1'b1;
  endtask

  task automatic pop_one();
    check("pop_head", dout_ps2_rx, q[0]);
    rd_ps2_rx = 1'b1;
    tick();
    rd_ps2_rx = 1'b0;
    void'(q.pop_front());
    ovr_m = 1'b0;
    check("pop_empty", empty_ps2_rx, q.size() == 0);
    check("pop_overrun", overrun_ps2_rx, 0);
  endtask

  // Reference: classify the frame from its bits, then apply it to a queue of bytes.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic st, input logic sp,
                             input int half, input bit glitch, input bit rd_chk);
    int ed = 0, ep = 0, ef = 0;
    snap();
    send_frame(d, par, st, sp, half, glitch, 0, rd_chk);
    if (st !== 1'b0 || sp !== 1'b1) ef = 1;
    else if ((^d ^ par) != 1'b1) ep = 1;
    else begin
      if (rd_chk) begin
        void'(q.pop_front());
        ovr_m = 1'b0;
      end
      if (q.size() == DEPTH) ovr_m = 1'b1;
      else begin
        q.push_back(d);
        ed = 1;
      end
    end
    expect_pulses(ed, ep, ef);
    check("overrun", overrun_ps2_rx, ovr_m);
    check("empty", empty_ps2_rx, q.size() == 0);
    if (q.size() != 0) check("head", dout_ps2_rx, q[0]);
  endtask

  initial begin
    int err_at;
    vt[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 0, 1, 0, 0};
    vt[1]  = '{8'hA5, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0};
    vt[2]  = '{8'h55, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1};
    vt[3]  = '{8'h55, 1'b1, 1'b1, 1'b1, 0, 0, 0, 1};
    vt[4]  = '{8'h3A, 1'b1, 1'b0, 1'b1, 0, 1, 0, 0};
    vt[5]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 0, 1, 0, 0};
    vt[6]  = '{8'h80, 1'b0, 1'b0, 1'b1, 0, 1, 0, 0};
    vt[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0};
    vt[8]  = '{8'hC3, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1};
    vt[9]  = '{8'h96, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0};
    vt[10] = '{8'h96, 1'b1, 1'b0, 1'b1, 2, 1, 0, 0};

    reset_ps2_rx = 1'b1; ps2d_ps2_rx = 1'b1; ps2c_ps2_rx = 1'b1; rx_en_ps2_rx = 1'b1; rd_ps2_rx = 1'b0;
    tick(); tick();
    reset_ps2_rx = 1'b0;
    check("rst_empty", empty_ps2_rx, 1);
    check("rst_dout", dout_ps2_rx, 0);
    check("rst_busy", busy_ps2_rx, 0);
    check("rst_overrun", overrun_ps2_rx, 0);
    check("rst_pulses", {rx_done_tick_ps2_rx, parity_err_ps2_rx, frame_err_ps2_rx}, 0);
    repeat (20) tick();

    for (int i = 0; i < 11; i++) begin
      snap();
      send_frame(vt[i].d, vt[i].par, vt[i].st, vt[i].sp, 40, 1'b0, vt[i].en_mode, 1'b0);
      expect_pulses(vt[i].e_done, vt[i].e_perr, vt[i].e_ferr);
      check("vec_empty", empty_ps2_rx, vt[i].e_done == 0);
      check("vec_busy", busy_ps2_rx, 0);
      if (vt[i].e_done != 0) begin
        q.push_back(vt[i].d);
        pop_one();
      end
    end

    // Stalled frame: start + 3 data bits, then the clock stays high.
    snap();
    drive_bit(1'b0, 40, 1'b0, 1'b0);
    drive_bit(1'b1, 40, 1'b0, 1'b0);
    drive_bit(1'b0, 40, 1'b0, 1'b0);
    ps2d_ps2_rx = 1'b1;
    repeat (40) tick();
    ps2c_ps2_rx = 1'b0;
    err_at = -1;
    for (int i = 1; i <= FL + TO + 50 && err_at < 0; i++) begin
      tick();
      if (i == 40) ps2c_ps2_rx = 1'b1;
      if (frame_err_ps2_rx) err_at = i;
    end
    check("timeout_cycle", err_at, FL + TO);
    tick();
    check("timeout_busy", busy_ps2_rx, 0);
    ps2c_ps2_rx = 1'b1;
    repeat (20) tick();
    expect_pulses(0, 0, 1);
    check("timeout_empty", empty_ps2_rx, 1);
    model_frame(8'h3A, 1'b1, 1'b0, 1'b1, 40, 1'b0, 1'b0);
    pop_one();

    // Overrun: one more good frame than the FIFO holds.
    for (int k = 1; k <= 5; k++)
      model_frame(8'(k), ~^8'(k), 1'b0, 1'b1, 40, 1'b0, 1'b0);
    check("overrun_after_5", overrun_ps2_rx, 1);
    for (int k = 0; k < 4; k++) pop_one();
    for (int k = 1; k <= 4; k++)
      model_frame(8'(8'h10 + k), ~^8'(8'h10 + k), 1'b0, 1'b1, 40, 1'b0, 1'b0);
    model_frame(8'h15, ~^8'h15, 1'b0, 1'b1, 40, 1'b0, 1'b1);
    while (q.size() > 0) pop_one();

    // Short clock glitches while idle must not start a frame.
    snap();
    for (int k = 0; k < 3; k++) begin
      ps2c_ps2_rx = 1'b0;
      repeat (3) tick();
      ps2c_ps2_rx = 1'b1;
      repeat (10) tick();
      check("glitch_busy", busy_ps2_rx, 0);
    end
    expect_pulses(0, 0, 0);
    model_frame(8'h5E, ~^8'h5E, 1'b0, 1'b1, 40, 1'b1, 1'b0);

    // Reset in the middle of a frame.
    model_frame(8'h42, ~^8'h42, 1'b0, 1'b1, 40, 1'b0, 1'b0);
    drive_bit(1'b0, 40, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive_bit(1'b1, 40, 1'b0, 1'b0);
    reset_ps2_rx = 1'b1;
    tick();
    reset_ps2_rx = 1'b0;
    check("midrst_busy", busy_ps2_rx, 0);
    check("midrst_empty", empty_ps2_rx, 1);
    check("midrst_dout", dout_ps2_rx, 0);
    q.delete();
    ovr_m = 1'b0;
    repeat (20) tick();
    model_frame(8'h6B, 1'b0, 1'b0, 1'b1, 40, 1'b0, 1'b0);
    pop_one();

    for (int k = 0; k < 25; k++) begin
      logic [7:0] d;
      logic       par, st, sp;
      int         r, np;
      r   = int'($urandom_range(0, 9));
      d   = 8'($urandom);
      par = ~^d;
      st  = 1'b0;
      sp  = 1'b1;
      if (r == 0) st = 1'b1;
      else if (r == 1) sp = 1'b0;
      else if (r == 2) par = ~par;
      model_frame(d, par, st, sp, int'($urandom_range(20, 50)), ($urandom_range(0, 1) == 1), 1'b0);
      np = int'($urandom_range(0, 2));
      for (int j = 0; j < np && q.size() > 0; j++) pop_one();
    end
    while (q.size() > 0) pop_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
